// File: rtl/encrypt.sv
// Iterative AES-128 encryption core: one cipher round per clock, key expanded on the fly.
// Build option ENCRYPT_CLEAR_ON_LOAD_EN: a load edge also clears ciphertext.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] xx;
      p  = 8'h00;
      xx = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ xx;
         xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] sq;
   logic [7:0] inv;

   // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0)
   always_comb begin
      sq  = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
   end

   assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_mix_col (
   input  logic [31:0] col,
   output logic [31:0] mixed
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] a0, a1, a2, a3;
   assign {a0, a1, a2, a3} = col;

   assign mixed = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
endmodule

module encrypt (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [0:127] plaintext,
   input  logic [0:127] key,
   output logic [0:127] ciphertext
);
   logic [0:127] state;
   logic [0:127] round_key;
   logic [3:0]   round;
   logic         busy;

   logic [0:127] sb, sr, mc, next_key, rnd_out;
   logic [31:0]  key_rot, key_sub;
   logic [31:0]  nk0, nk1, nk2, nk3;
   logic [7:0]   rcon;
   logic         last_round;

   genvar g;
   generate
      for (g = 0; g < 16; g++) begin : g_byte
         // ShiftRows: byte at (row r, col c) comes from (row r, col c+r)
         localparam int SRC = 4 * (((g / 4) + (g % 4)) % 4) + (g % 4);
         aes_sbox u_sbox (.a(state[8*g +: 8]), .y(sb[8*g +: 8]));
         assign sr[8*g +: 8] = sb[8*SRC +: 8];
      end
      for (g = 0; g < 4; g++) begin : g_col
         aes_mix_col u_mix (.col(sr[32*g +: 32]), .mixed(mc[32*g +: 32]));
         aes_sbox    u_ksbox (.a(key_rot[8*g +: 8]), .y(key_sub[8*g +: 8]));
      end
   endgenerate

   // RotWord of the last key word: bytes 13,14,15,12
   assign key_rot = {round_key[104 +: 8], round_key[112 +: 8],
                     round_key[120 +: 8], round_key[96 +: 8]};

   always_comb begin
      rcon = 8'h00;
      case (round)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign nk0      = round_key[0  +: 32] ^ key_sub ^ {rcon, 24'h000000};
   assign nk1      = round_key[32 +: 32] ^ nk0;
   assign nk2      = round_key[64 +: 32] ^ nk1;
   assign nk3      = round_key[96 +: 32] ^ nk2;
   assign next_key = {nk0, nk1, nk2, nk3};

   assign last_round = (round == 4'd10);
   assign rnd_out    = (last_round ? sr : mc) ^ next_key;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= '0;
         round_key  <= '0;
         round      <= 4'd0;
         busy       <= 1'b0;
         ciphertext <= '0;
      end else if (enable) begin
         state     <= plaintext ^ key;
         round_key <= key;
         round     <= 4'd1;
         busy      <= 1'b1;
`ifdef ENCRYPT_CLEAR_ON_LOAD_EN
         ciphertext <= '0;
`endif
      end else if (busy) begin
         state     <= rnd_out;
         round_key <= next_key;
         if (last_round) begin
            ciphertext <= rnd_out;
            busy       <= 1'b0;
            round      <= 4'd0;
         end else begin
            round <= round + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_encrypt.sv
// Self-checking bench for encrypt: known-answer vectors, abort/reset cases and random blocks vs a reference AES.
module tb_encrypt;
   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic [0:127] plaintext;
   logic [0:127] key;
   logic [0:127] ciphertext;

   int errors = 0;
   int checks = 0;
   logic [0:127] last_ct;
   logic [7:0]   sbt [256];

   encrypt dut (
      .clk(clk), .reset(reset), .enable(enable),
      .plaintext(plaintext), .key(key), .ciphertext(ciphertext)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box table: brute-force inverse, then FIPS-197 affine map bit by bit
   task automatic build_sbox();
      logic [7:0] inv, s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbt[x] = s;
      end
   endtask

   function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:127] k);
      logic [31:0]  w [44];
      logic [31:0]  temp;
      logic [7:0]   rc;
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [0:127] rk, out;
      for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         temp = w[i-1];
         if (i % 4 == 0) begin
            temp = {temp[23:0], temp[31:24]};
            temp = {sbt[temp[31:24]], sbt[temp[23:16]], sbt[temp[15:8]], sbt[temp[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ temp;
      end
      rk = {w[0], w[1], w[2], w[3]};
      for (int b = 0; b < 16; b++) s[b] = pt[8*b +: 8] ^ rk[8*b +: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int b = 0; b < 16; b++) t[b] = sbt[s[b]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
         if (r < 10)
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         for (int b = 0; b < 16; b++) s[b] = s[b] ^ rk[8*b +: 8];
      end
      for (int b = 0; b < 16; b++) out[8*b +: 8] = s[b];
      return out;
   endfunction

   function automatic logic [0:127] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [0:127] obs, input logic [0:127] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [0:127] pt, input logic [0:127] k);
      plaintext = pt;
      key       = k;
      enable    = 1'b1;
      tick();
      enable    = 1'b0;
`ifdef ENCRYPT_CLEAR_ON_LOAD_EN
      last_ct = '0;
`endif
   endtask

   task automatic rounds(input int n, input bit perturb);
      for (int i = 0; i < n; i++) begin
         if (perturb) begin
            plaintext = rnd128();
            key       = rnd128();
         end
         tick();
         check("hold_during_run", ciphertext, last_ct);
      end
   endtask

   task automatic complete(input string tag, input logic [0:127] exp);
      tick();
      check(tag, ciphertext, exp);
      last_ct = exp;
   endtask

   localparam logic [0:127] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [0:127] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [0:127] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [0:127] PT_C = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] CT_0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   initial begin
      logic [0:127] pt, k, lp, lk;
      build_sbox();
      reset = 1'b0; enable = 1'b0; plaintext = '0; key = '0;
      last_ct = '0;

      // Reset, then idle
      tick(); tick();
      check("reset_ct", ciphertext, 128'h0);
      reset = 1'b1;
      rounds(3, 1'b0);

      // All-zero vector, then hold stable
      load(128'h0, 128'h0);
      rounds(9, 1'b0);
      complete("zero_vec", CT_0);
      rounds(6, 1'b0);

      // FIPS-197 appendix B: result on 10th edge, not the 9th
      load(PT_B, K_B);
      rounds(9, 1'b0);
      complete("fips_b", CT_B);

      // Appendix C.1 with inputs churning during the rounds
      load(PT_C, K_C);
      rounds(9, 1'b1);
      complete("fips_c_perturbed", CT_C);

      // Reference model self-consistency on a known vector via the DUT path
      load(128'h0, 128'h0);
      rounds(9, 1'b0);
      complete("zero_vec_model", aes_ref(128'h0, 128'h0));

      // Abort at round 5 with a reload of vector C
      load(PT_B, K_B);
      rounds(4, 1'b0);
      load(PT_C, K_C);
      rounds(9, 1'b0);
      complete("abort_r5", CT_C);

      // Load on the very edge round 10 would complete: load wins
      load(PT_B, K_B);
      rounds(9, 1'b0);
      load(PT_C, K_C);
      check("late_abort_no_update", ciphertext, last_ct);
      rounds(9, 1'b0);
      complete("late_abort_result", CT_C);

      // Reset at round 6: everything clears, nothing appears afterwards
      load(PT_B, K_B);
      rounds(5, 1'b0);
      reset = 1'b0;
      tick();
      check("reset_mid_run", ciphertext, 128'h0);
      reset = 1'b1;
      last_ct = '0;
      rounds(12, 1'b0);

      // Enable held high keeps reloading and never completes
      lp = '0; lk = '0;
      enable = 1'b1;
      for (int i = 0; i < 15; i++) begin
         lp = rnd128(); lk = rnd128();
         plaintext = lp; key = lk;
         tick();
`ifdef ENCRYPT_CLEAR_ON_LOAD_EN
         last_ct = '0;
`endif
         check("enable_held", ciphertext, last_ct);
      end
      enable = 1'b0;
      rounds(9, 1'b0);
      complete("after_enable_held", aes_ref(lp, lk));

      // Random blocks against the reference model
      for (int n = 0; n < 8; n++) begin
         pt = rnd128();
         k  = rnd128();
         load(pt, k);
         rounds(9, (n % 2) == 1);
         complete("random_block", aes_ref(pt, k));
         if (n % 3 == 0) rounds(1 + (n % 4), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
